// File: rtl/digdug_pkg.sv
// ============================================================================
// Module      : digdug_pkg
// Description : Shared constants and types for the DigDug sprite attribute
//               table: bank indices, table geometry and copy FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package digdug_pkg;

    // Shadow bank indices as seen on the CPU BANK select
    localparam logic [1:0] BANK_CODE = 2'd0;   // code / colour
    localparam logic [1:0] BANK_POS  = 2'd1;   // position
    localparam logic [1:0] BANK_ATTR = 2'd2;   // flip / size / disable
    localparam logic [1:0] BANK_NONE = 2'd3;   // unmapped

    // Table geometry
    localparam int SPAT_DEPTH = 128;
    localparam int SPAT_W     = 24;

    // Shadow-to-display copy sequencer
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COPY  = 2'd1,
        ST_DRAIN = 2'd2
    } spat_state_t;

endpackage

`default_nettype wire

// File: rtl/digdug_dpram.sv
// ============================================================================
// Module      : digdug_dpram
// Description : Generic synchronous dual-port RAM. Port A is read/write with
//               a read enable (output holds when not reading), port B is
//               read-only and reads every cycle. Reads are read-before-write.
//               Output registers reset to zero; the array is not cleared.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digdug_dpram
    import digdug_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = SPAT_DEPTH,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [W-1:0]  wdata_a,
    output logic [W-1:0]  rdata_a,
    input  logic [AW-1:0] addr_b,
    output logic [W-1:0]  rdata_b
);

    logic [W-1:0] mem [DEPTH];

    // Array write through port A
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= wdata_a;
        end
    end

    // Registered read ports; old contents are returned on a same-cycle write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (en_a) begin
                rdata_a <= mem[addr_a];
            end
            rdata_b <= mem[addr_b];
        end
    end

endmodule

`default_nettype wire

// File: rtl/digdug_spatr_writer.sv
// ============================================================================
// Module      : digdug_spatr_writer
// Description : CPU-side owner of the DigDug sprite attribute table. Three
//               128-byte shadow banks take Z80 accesses. With
//               DIGDUG_SPATR_DBUF_EN defined, each VBLK rise copies all banks
//               into a 128x24 display buffer read by the renderer; without
//               it the renderer reads the shadow banks directly.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digdug_spatr_writer
    import digdug_pkg::*;
#(
    parameter int DEPTH = SPAT_DEPTH,
    parameter int AW    = 7
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CS,
    input  logic [1:0]        BANK,
    input  logic [AW-1:0]     AD,
    input  logic              WR,
    input  logic              RD,
    input  logic [7:0]        DI,
    output logic [7:0]        DO,
    input  logic              VBLK,
    input  logic [AW-1:0]     SPATAD,
    output logic [SPAT_W-1:0] SPATDT,
    output logic              BUSY,
    output logic              OVRUN
);

    logic [2:0]    cpu_we;
    logic [2:0]    cpu_re;
    logic [7:0]    cpu_rdata    [3];
    logic [7:0]    shadow_rdata [3];
    logic [AW-1:0] shadow_raddr;
    logic [1:0]    rd_bank;
    logic [7:0]    do_mux;

    // One shadow RAM per mapped bank; CPU on port A, copy/renderer on port B
    for (genvar g = 0; g < 3; g++) begin : g_bank
        assign cpu_we[g] = CS && WR && (BANK == 2'(g));
        assign cpu_re[g] = CS && RD && (BANK == 2'(g));

        digdug_dpram #(.W(8), .DEPTH(DEPTH), .AW(AW)) u_shadow (
            .clk     (CLK),
            .rst_n   (RST_N),
            .en_a    (cpu_re[g]),
            .we_a    (cpu_we[g]),
            .addr_a  (AD),
            .wdata_a (DI),
            .rdata_a (cpu_rdata[g]),
            .addr_b  (shadow_raddr),
            .rdata_b (shadow_rdata[g])
        );
    end

    // Remember which bank the last CPU read targeted so DO holds between reads
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_bank <= BANK_CODE;
        end else if (CS && RD) begin
            rd_bank <= BANK;
        end
    end

    // CPU read data select; the unmapped bank reads as all ones
    always_comb begin
        do_mux = 8'hFF;
        case (rd_bank)
            BANK_CODE: do_mux = cpu_rdata[0];
            BANK_POS:  do_mux = cpu_rdata[1];
            BANK_ATTR: do_mux = cpu_rdata[2];
            default:   do_mux = 8'hFF;
        endcase
    end

    assign DO = do_mux;

`ifdef DIGDUG_SPATR_DBUF_EN

    spat_state_t        state;
    spat_state_t        state_nx;
    logic [AW-1:0]      n;
    logic [AW-1:0]      n_nx;
    logic               vblk_q;
    logic               vblk_rise;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic               ovrun;
    logic [SPAT_W-1:0]  disp_a_unused;

    assign vblk_rise    = VBLK && !vblk_q;
    assign shadow_raddr = n;

    // Copy sequencer state, address counter, edge detect and write pipeline
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= ST_IDLE;
            n       <= '0;
            vblk_q  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            ovrun   <= 1'b0;
        end else begin
            state   <= state_nx;
            n       <= n_nx;
            vblk_q  <= VBLK;
            wr_en   <= (state == ST_COPY);
            wr_addr <= n;
            ovrun   <= vblk_rise && (state != ST_IDLE);
        end
    end

    // Next-state and counter logic; a rise while busy is not restarted
    always_comb begin
        state_nx = state;
        n_nx     = n;
        case (state)
            ST_IDLE: begin
                n_nx = '0;
                if (vblk_rise) begin
                    state_nx = ST_COPY;
                end
            end
            ST_COPY: begin
                n_nx = n + AW'(1);
                if (n == AW'(DEPTH - 1)) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                n_nx     = '0;
                state_nx = ST_IDLE;
            end
            default: begin
                n_nx     = '0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Frame-coherent display buffer: written by the copy, read by the renderer
    digdug_dpram #(.W(SPAT_W), .DEPTH(DEPTH), .AW(AW)) u_display (
        .clk     (CLK),
        .rst_n   (RST_N),
        .en_a    (1'b0),
        .we_a    (wr_en),
        .addr_a  (wr_addr),
        .wdata_a ({shadow_rdata[2], shadow_rdata[1], shadow_rdata[0]}),
        .rdata_a (disp_a_unused),
        .addr_b  (SPATAD),
        .rdata_b (SPATDT)
    );

    assign BUSY  = (state != ST_IDLE);
    assign OVRUN = ovrun;

`else

    logic vblk_unused;

    // Renderer reads the shadow banks directly
    assign shadow_raddr = SPATAD;
    assign SPATDT       = {shadow_rdata[2], shadow_rdata[1], shadow_rdata[0]};
    assign BUSY         = 1'b0;
    assign OVRUN        = 1'b0;
    assign vblk_unused  = VBLK;

`endif

endmodule

`default_nettype wire
